fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/if_id_reg.sv | 84 ++++++++
 rtl/fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch stage.
// Holds the NOP encoding, the default reset PC, the IF/ID state encoding
// and the PC increment helper.
package riscv_pkg;

  // Canonical NOP (addi x0, x0, 0), used as the IF/ID bubble instruction
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // IF/ID occupancy: BUBBLE means ValidD=0, VALID means a real instruction
  typedef enum logic [0:0] {
    FETCH_BUBBLE = 1'b0,
    FETCH_VALID  = 1'b1
  } fetch_state_e;

  // Sequential next PC; wraps modulo 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall (hold) and flush (bubble load).
// Flush has priority over stall. Occupancy is tracked as a two-state FSM.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_plus4_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  fetch_state_e state_r;
  fetch_state_e state_next_s;
  logic [31:0]  instr_r;
  logic [31:0]  pc_r;
  logic [31:0]  pc_plus4_r;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH_BUBBLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy: flush empties, an unstalled capture fills, else hold
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH_BUBBLE: begin
        if (flush) begin
          state_next_s = FETCH_BUBBLE;
        end else if (!stall) begin
          state_next_s = FETCH_VALID;
        end else begin
          state_next_s = FETCH_BUBBLE;
        end
      end
      FETCH_VALID: begin
        if (flush) begin
          state_next_s = FETCH_BUBBLE;
        end else begin
          state_next_s = FETCH_VALID;
        end
      end
      default: state_next_s = FETCH_BUBBLE;
    endcase
  end

  // Payload register: bubble on reset/flush, capture when not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
    end else if (flush) begin
      instr_r    <= NOP_INSTR;
      pc_r       <= 32'h0000_0000;
      pc_plus4_r <= 32'h0000_0000;
    end else if (!stall) begin
      instr_r    <= instr_f;
      pc_r       <= pc_f;
      pc_plus4_r <= pc_plus4_f;
    end else begin
      instr_r    <= instr_r;
      pc_r       <= pc_r;
      pc_plus4_r <= pc_plus4_r;
    end
  end

  assign instr_d    = instr_r;
  assign pc_d       = pc_r;
  assign pc_plus4_d = pc_plus4_r;
  assign valid_d    = (state_r == FETCH_VALID);

endmodule

// File: rtl/fetch_stage.sv
// RISC-V fetch stage: PC register, PC+4 adder and IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds StallCntF / FlushCntD counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PCFp,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic [31:0]      InstrF,
  output logic [31:0]      PCF,
  output logic [31:0]      PCPlus4F,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCntF,
  output logic [CNT_W-1:0] FlushCntD
`endif
);

  logic [31:0] pc_r;

  // A zero-width counter is meaningless; this empty block only exists to
  // make an out-of-range CNT_W visible in the elaborated hierarchy.
  if (CNT_W < 1) begin : g_cnt_w_out_of_range
  end

  // Fetch PC register: load next PC unless fetch is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (!StallF) begin
      pc_r <= PCFp;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign PCF      = pc_r;
  assign PCPlus4F = pc_plus4(pc_r);

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (StallD),
    .flush      (FlushD),
    .instr_f    (InstrF),
    .pc_f       (pc_r),
    .pc_plus4_f (PCPlus4F),
    .instr_d    (InstrD),
    .pc_d       (PCD),
    .pc_plus4_d (PCPlus4D),
    .valid_d    (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Performance counters: one count per stalled / flushed edge, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      stall_cnt_r <= StallF ? (stall_cnt_r + CNT_W'(1)) : stall_cnt_r;
      flush_cnt_r <= FlushD ? (flush_cnt_r + CNT_W'(1)) : flush_cnt_r;
    end
  end

  assign StallCntF = stall_cnt_r;
  assign FlushCntD = flush_cnt_r;
`endif

endmodule
